// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between 16 requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter16_if #(
  parameter int unsigned CNT_W = 4
);
  logic [15:0]      req;
  logic [15:0]      gnt;
  logic [3:0]       gnt_idx;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, hold_cnt
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, hold_cnt
  );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot/encoded grant and a
// bounded hold time so a persistent owner cannot starve competitors.
module rr_arbiter16 #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter16_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [15:0]      gnt_q, gnt_d;
  logic [3:0]       gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       last_idx_q, last_idx_d;

  logic [15:0]      others;
  logic [4:0]       pick;

  // Returns {found, index}; later loop iterations override earlier ones, so
  // the candidate right after 'last' (offset 1) ends up with top priority.
  function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] last);
    logic [4:0] res;
    logic [3:0] cand;
    res = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      cand = last + 4'(16 - k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // The current owner is masked out, so one search serves idle arbitration,
  // handoff on release and forced rotation alike.
  assign others = bus.req & ~gnt_q;
  assign pick   = rr_pick(others, last_idx_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    last_idx_d  = last_idx_q;

    unique case (state_q)
      IDLE: begin
        if (pick[4]) begin
          state_d     = GRANT;
          gnt_idx_d   = pick[3:0];
          last_idx_d  = pick[3:0];
          gnt_d       = 16'(1) << pick[3:0];
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (!bus.req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST)) begin
          if (pick[4]) begin
            gnt_idx_d   = pick[3:0];
            last_idx_d  = pick[3:0];
            gnt_d       = 16'(1) << pick[3:0];
            gnt_valid_d = 1'b1;
            hold_cnt_d  = '0;
          end else if (!bus.req[gnt_idx_q]) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      last_idx_q  <= 4'hF;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      last_idx_q  <= last_idx_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: directed scenarios plus random traffic, all checked
// against an owner/last/cycles-held reference model.
module tb_rr_arbiter16;

  localparam int HOLD_MAX = 8;
  localparam int CNT_W    = 4;

  logic clk;
  logic rst_n;

  rr_arbiter16_if #(.CNT_W(CNT_W)) bus ();

  rr_arbiter16 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = none), last winner, whole cycles owned so far.
  int m_owner, m_last, m_held;

  function automatic int search(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (r[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 15;
      m_held  <= 0;
    end else begin
      int o, l, h, w;
      logic [15:0] oth;
      o = m_owner; l = m_last; h = m_held;
      oth = bus.req;
      if (o >= 0) oth[o] = 1'b0;
      w = search(oth, l);
      if (o < 0) begin
        if (w >= 0) begin o = w; l = w; h = 1; end
      end else if (!bus.req[o]) begin
        if (w >= 0) begin o = w; l = w; h = 1; end
        else begin o = -1; h = 0; end
      end else if (h >= HOLD_MAX && w >= 0) begin
        o = w; l = w; h = 1;
      end else begin
        h = h + 1;
      end
      m_owner <= o;
      m_last  <= l;
      m_held  <= h;
    end
  end

  always @(negedge clk) begin
    logic [15:0] eg;
    int eh;
    eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    eh = (m_owner >= 0) ? ((m_held - 1 < HOLD_MAX - 1) ? m_held - 1 : HOLD_MAX - 1) : 0;
    chk("model_gnt", 32'(bus.gnt), 32'(eg));
    chk("model_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    chk("model_hold", 32'(bus.hold_cnt), 32'(eh));
    if (m_owner >= 0) chk("model_idx", 32'(bus.gnt_idx), 32'(m_owner));
    assert (!bus.gnt_valid || bus.gnt == (16'd1 << bus.gnt_idx))
      else $error("gnt not decode of gnt_idx");
    assert (bus.gnt_valid || bus.gnt == 16'd0)
      else $error("gnt set while not valid");
  end

  task automatic do_reset();
    bus.req = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_valid", 32'(bus.gnt_valid), 32'h0);
    chk("rst_idx", 32'(bus.gnt_idx), 32'h0);
    chk("rst_hold", 32'(bus.hold_cnt), 32'h0);

    // First grant after reset goes to requester 0 with one-cycle latency.
    do_reset();
    bus.req = 16'h0001;
    @(negedge clk);
    chk("first_gnt", 32'(bus.gnt), 32'h0001);
    chk("first_idx", 32'(bus.gnt_idx), 32'h0);
    chk("first_valid", 32'(bus.gnt_valid), 32'h1);

    // All request, each owner releases after one cycle: 0..15 then 0.
    do_reset();
    bus.req = 16'hFFFF;
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk);
      chk("rot_idx", 32'(bus.gnt_idx), 32'(n % 16));
      chk("rot_valid", 32'(bus.gnt_valid), 32'h1);
      bus.req = 16'hFFFF & ~bus.gnt;
    end

    // Owner 5 holds, 9 waits: exactly HOLD_MAX cycles at 5 then 9.
    do_reset();
    bus.req = 16'h0020;
    @(negedge clk);
    chk("hold_start", 32'(bus.gnt_idx), 32'h5);
    bus.req = 16'h0220;
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt_idx == 4'd5 && bus.gnt_valid) cnt++;
      else break;
    end
    chk("hold_cycles", 32'(cnt), 32'(HOLD_MAX));
    chk("hold_next", 32'(bus.gnt_idx), 32'h9);

    // Owner 15 releases with 0 and 1 requesting: wrap to 0.
    do_reset();
    bus.req = 16'h8000;
    @(negedge clk);
    chk("wrap_own", 32'(bus.gnt_idx), 32'hF);
    bus.req = 16'h0003;
    @(negedge clk);
    chk("wrap_idx", 32'(bus.gnt_idx), 32'h0);

    // Sole requester keeps the grant; counter saturates.
    do_reset();
    bus.req = 16'h0008;
    repeat (40) @(negedge clk);
    chk("sole_gnt", 32'(bus.gnt), 32'h0008);
    chk("sole_hold", 32'(bus.hold_cnt), 32'(HOLD_MAX - 1));

    // Async reset mid-grant, then restart with requester 8.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_valid", 32'(bus.gnt_valid), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 16'h0100;
    @(negedge clk);
    chk("after_rst_idx", 32'(bus.gnt_idx), 32'h8);
    chk("after_rst_gnt", 32'(bus.gnt), 32'h0100);

    // Random traffic: mixes sparse/dense patterns, holds, and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 4))
        0:       bus.req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        1:       bus.req = 16'($urandom);
        2:       bus.req = bus.req & ~bus.gnt;
        3:       bus.req = bus.req;
        default: bus.req = 16'd1 << $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rand_async_gnt", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
